// File: rtl/uart_pkg.sv
// Shared types and widths for the UART receive path.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_CNT_W     = 12;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; a push into a full FIFO succeeds
// only when a pop frees a slot in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                      clk_core,
    input  logic                      reset,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] push_data,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] head,
    output logic                      empty,
    output logic                      full,
    output logic [DEPTH_LOG2:0]       count
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0] PTR_MSB = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [UART_DATA_BITS-1:0] mem_r [DEPTH];
    logic [DEPTH_LOG2:0]       wr_ptr_r;
    logic [DEPTH_LOG2:0]       rd_ptr_r;
    logic                      do_pop_s;
    logic                      do_push_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = ((wr_ptr_r ^ rd_ptr_r) == PTR_MSB);
    assign count     = wr_ptr_r - rd_ptr_r;
    assign head      = mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Storage and pointer update.
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {(DEPTH_LOG2 + 1){1'b0}};
            rd_ptr_r <= {(DEPTH_LOG2 + 1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {UART_DATA_BITS{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= push_data;
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver feeding a small FWFT FIFO with sticky error flags.
// Optional flow control output enabled by defining UART_RX_CTS_EN.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 347,
    parameter int DEPTH_LOG2   = 2
) (
    input  logic       clk_core,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_pop,
    output logic       framing_err,
    output logic       overrun_err,
    input  logic       err_clr,
    output logic       rts_n
);

    localparam logic [UART_CNT_W-1:0] CNT_HALF = UART_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [UART_CNT_W-1:0] CNT_FULL = UART_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [UART_CNT_W-1:0] CNT_ONE  = {{(UART_CNT_W - 1){1'b0}}, 1'b1};

    logic                      sync1_r;
    logic                      sync2_r;
    logic                      rx_s;
    uart_state_t               state_r;
    logic [UART_CNT_W-1:0]     cnt_r;
    logic [2:0]                idx_r;
    logic [UART_DATA_BITS-1:0] shift_r;
    logic                      cnt_zero_s;
    logic                      push_s;
    logic                      frame_bad_s;
    logic                      overrun_set_s;
    logic                      fifo_empty_s;
    logic                      fifo_full_s;
    logic                      framing_err_r;
    logic                      overrun_err_r;

    assign rx_s          = sync2_r;
    assign cnt_zero_s    = (cnt_r == {UART_CNT_W{1'b0}});
    assign push_s        = (state_r == STOP) && cnt_zero_s && rx_s;
    assign frame_bad_s   = (state_r == STOP) && cnt_zero_s && !rx_s;
    // Full implies non-empty, so a pop here always frees a slot.
    assign overrun_set_s = push_s && fifo_full_s && !rx_pop;

    assign rx_valid    = !fifo_empty_s;
    assign framing_err = framing_err_r;
    assign overrun_err = overrun_err_r;

    // Two-flop synchroniser for the asynchronous pad input.
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
        end
    end

    // Frame sequencer: start qualification, bit sampling, stop check.
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= {UART_CNT_W{1'b0}};
            idx_r   <= 3'd0;
            shift_r <= {UART_DATA_BITS{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (!rx_s) begin
                        cnt_r   <= CNT_HALF;
                        state_r <= START;
                    end
                end
                START: begin
                    if (!cnt_zero_s) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else if (!rx_s) begin
                        cnt_r   <= CNT_FULL;
                        idx_r   <= 3'd0;
                        state_r <= DATA;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DATA: begin
                    if (!cnt_zero_s) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else begin
                        shift_r <= {rx_s, shift_r[UART_DATA_BITS-1:1]};
                        cnt_r   <= CNT_FULL;
                        if (idx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (!cnt_zero_s) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else if (rx_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT_HI;
                    end
                end
                // Hold off until the line idles so a break is not re-read as start bits.
                WAIT_HI: begin
                    if (rx_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a fresh error wins over a simultaneous clear.
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            framing_err_r <= 1'b0;
            overrun_err_r <= 1'b0;
        end else begin
            if (frame_bad_s) begin
                framing_err_r <= 1'b1;
            end else if (err_clr) begin
                framing_err_r <= 1'b0;
            end
            if (overrun_set_s) begin
                overrun_err_r <= 1'b1;
            end else if (err_clr) begin
                overrun_err_r <= 1'b0;
            end
        end
    end

`ifdef UART_RX_CTS_EN
    localparam logic [DEPTH_LOG2:0] RTS_LEVEL = (DEPTH_LOG2 + 1)'(2 ** DEPTH_LOG2 - 1);

    logic [DEPTH_LOG2:0] fifo_count_s;
    logic                rts_n_r;

    // Deassert ready-to-send once only one free slot remains.
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            rts_n_r <= 1'b0;
        end else begin
            rts_n_r <= (fifo_count_s >= RTS_LEVEL);
        end
    end

    assign rts_n = rts_n_r;
`else
    assign rts_n = 1'b0;
`endif

    uart_rx_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk_core (clk_core),
        .reset    (reset),
        .push     (push_s),
        .push_data(shift_r),
        .pop      (rx_pop),
        .head     (rx_data),
        .empty    (fifo_empty_s),
        .full     (fifo_full_s),
`ifdef UART_RX_CTS_EN
        .count    (fifo_count_s)
`else
        .count    ()
`endif
    );

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core; reference is a byte queue plus two
// sticky flags. Honours UART_RX_CTS_EN when checking rts_n.
module tb_uart_rx_core;

    localparam int CPB   = 8;
    localparam int DL    = 2;
    localparam int DEPTH = 4;
    // Edges from the start-bit drop to the stop-bit sample: 2 sync + 1 detect
    // + half a bit to the start sample + 9 full bits.
    localparam int STOP_SAMPLE = 3 + CPB / 2 + 9 * CPB;

    logic       clk_core = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_pop;
    logic       framing_err;
    logic       overrun_err;
    logic       err_clr;
    logic       rts_n;

    int n_assert = 0;
    int n_fail   = 0;

    byte unsigned q[$];
    bit           m_fe;
    bit           m_ovr;

    int   cyc;
    int   pop_at = -1;
    int   rise_cyc;
    logic prev_valid;

    uart_rx_core #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL)) dut (
        .clk_core   (clk_core),
        .reset      (reset),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_pop     (rx_pop),
        .framing_err(framing_err),
        .overrun_err(overrun_err),
        .err_clr    (err_clr),
        .rts_n      (rts_n)
    );

    always #5 clk_core = ~clk_core;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_core);
        #1;
        cyc++;
        rx_pop = (cyc == pop_at);
        if (rx_valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
        prev_valid = rx_valid;
    endtask

    task automatic model_frame(input byte unsigned d, input bit stop_ok, input bit popped);
        if (!stop_ok) begin
            m_fe = 1'b1;
        end else begin
            if (popped && q.size() > 0) void'(q.pop_front());
            if (q.size() < DEPTH) q.push_back(d);
            else m_ovr = 1'b1;
        end
    endtask

    // Serial frame: start, 8 data bits LSB first, stop; optional pop on edge pa.
    task automatic send_frame(input byte unsigned d, input bit stop_ok, input int pa);
        step();
        cyc        = 0;
        rise_cyc   = -1;
        prev_valid = rx_valid;
        pop_at     = pa;
        rx = 1'b0;
        repeat (CPB) step();
        for (int b = 0; b < 8; b++) begin
            rx = d[b];
            repeat (CPB) step();
        end
        rx = stop_ok;
        repeat (stop_ok ? CPB : 40) step();
        rx = 1'b1;
        repeat (2 * CPB) step();
        pop_at = -1;
        model_frame(d, stop_ok, pa > 0);
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".valid"}, rx_valid, q.size() > 0);
        if (q.size() > 0) chk({tag, ".data"}, rx_data, q[0]);
        chk({tag, ".ferr"}, framing_err, m_fe);
        chk({tag, ".oerr"}, overrun_err, m_ovr);
`ifdef UART_RX_CTS_EN
        chk({tag, ".rts"}, rts_n, q.size() >= DEPTH - 1);
`else
        chk({tag, ".rts"}, rts_n, 1'b0);
`endif
    endtask

    task automatic pop_one(input string tag);
        if (q.size() > 0) chk({tag, ".head"}, rx_data, q[0]);
        rx_pop = 1'b1;
        @(posedge clk_core);
        #1;
        rx_pop = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        @(posedge clk_core);
        #1;
        check_state({tag, ".after"});
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(posedge clk_core);
        #1;
        err_clr = 1'b0;
        m_fe  = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".valid"}, rx_valid, 1'b0);
        chk({tag, ".data"}, rx_data, 8'h00);
        chk({tag, ".ferr"}, framing_err, 1'b0);
        chk({tag, ".oerr"}, overrun_err, 1'b0);
        chk({tag, ".rts"}, rts_n, 1'b0);
    endtask

    initial begin
        reset   = 1'b1;
        rx      = 1'b1;
        rx_pop  = 1'b0;
        err_clr = 1'b0;
        m_fe    = 1'b0;
        m_ovr   = 1'b0;
        repeat (3) @(posedge clk_core);
        #1;
        check_reset_values("reset");
        reset = 1'b0;

        // Single byte with latency check.
        send_frame(8'hA5, 1'b1, -1);
        chk("a5.latency", rise_cyc, STOP_SAMPLE);
        check_state("a5");
        chk("a5.const", rx_data, 8'hA5);
        pop_one("a5.pop");

        // Short low glitch must not produce a byte or an error.
        step();
        rx = 1'b0;
        step();
        step();
        rx = 1'b1;
        repeat (20) step();
        check_state("glitch");

        // Framing error, recovery, then clear.
        send_frame(8'h3C, 1'b0, -1);
        check_state("frame");
        send_frame(8'h55, 1'b1, -1);
        check_state("frame.next");
        chk("frame.next.const", rx_data, 8'h55);
        pop_one("frame.pop");
        clear_errors();
        check_state("frame.clr");

        // Overrun: fifth byte is dropped.
        for (int i = 1; i <= 5; i++) send_frame(byte'(i), 1'b1, -1);
        check_state("ovr");
        for (int i = 1; i <= 4; i++) begin
            chk("ovr.order", rx_data, i);
            pop_one("ovr.pop");
        end
        clear_errors();
        check_state("ovr.clr");

        // Full FIFO with a pop in the stop-sample cycle.
        for (int i = 1; i <= 4; i++) send_frame(byte'(i), 1'b1, -1);
        send_frame(8'h77, 1'b1, STOP_SAMPLE - 1);
        check_state("fullpop");
        chk("fullpop.count", q.size(), 4);
        while (q.size() > 0) pop_one("fullpop.drain");

        // Reset in the middle of a frame.
        send_frame(8'h11, 1'b1, -1);
        step();
        rx = 1'b0;
        repeat (CPB) step();
        for (int b = 0; b < 4; b++) begin
            rx = b[0];
            repeat (CPB) step();
        end
        reset = 1'b1;
        rx    = 1'b1;
        step();
        step();
        check_reset_values("midreset");
        reset = 1'b0;
        q.delete();
        m_fe  = 1'b0;
        m_ovr = 1'b0;
        send_frame(8'hC3, 1'b1, -1);
        check_state("c3");
        chk("c3.const", rx_data, 8'hC3);
        send_frame(8'h5A, 1'b1, -1);
        send_frame(8'h0F, 1'b1, -1);
        check_state("rts.three");
        pop_one("rts.pop");
        while (q.size() > 0) pop_one("rts.drain");

        // Randomised frames, pops and clears against the queue model.
        for (int it = 0; it < 30; it++) begin
            byte unsigned d;
            bit           ok;
            int           npop;
            d  = byte'($urandom_range(0, 255));
            ok = ($urandom_range(0, 7) != 0);
            send_frame(d, ok, -1);
            check_state("rand.frame");
            npop = $urandom_range(0, 2);
            for (int p = 0; p < npop; p++) pop_one("rand.pop");
            if ($urandom_range(0, 3) == 0) begin
                clear_errors();
                check_state("rand.clr");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
